// File: rtl/ipsmacge_txctrl_if.sv
// FIFO-side and insert-stage-side signals of the GE MAC TX framing controller.
// master = the controller itself, slave = its environment (FIFO + insert stage + CPU).
interface ipsmacge_txctrl_if #(
  parameter int DAT_DW = 8,
  parameter int CNT_DW = 6,
  parameter int STT_DW = 4
);
  logic              pena;
  logic              uptxen;
  logic              spdstable;
  logic              ifrmrdy;
  logic [DAT_DW-1:0] ifdat;
  logic              ifeop;
  logic              iferr;
  logic              ofrd;
  logic [STT_DW-1:0] osttm;
  logic [CNT_DW-1:0] ocnt;
  logic              osfd;
  logic [DAT_DW-1:0] odat;
  logic              oerr;
  logic              ocrcclr;
  logic              ocrcen;

  modport master (
    input  pena, uptxen, spdstable, ifrmrdy, ifdat, ifeop, iferr,
    output ofrd, osttm, ocnt, osfd, odat, oerr, ocrcclr, ocrcen
  );
  modport slave (
    output pena, uptxen, spdstable, ifrmrdy, ifdat, ifeop, iferr,
    input  ofrd, osttm, ocnt, osfd, odat, oerr, ocrcclr, ocrcen
  );
endinterface

// File: rtl/ipsmacge_txctrl.sv
// GE MAC transmit framing controller: sequences gap/preamble/payload/pad/FCS byte slots
// for the TX insert stage, pops the show-ahead TX frame FIFO and steers the CRC generator.
module ipsmacge_txctrl #(
  parameter int DAT_DW  = 8,
  parameter int CNT_DW  = 6,
  parameter int STT_DW  = 4,
  parameter int IPG_LEN = 12,
  parameter int PRM_LEN = 8,
  parameter int MIN_LEN = 60
) (
  input logic               txclk,
  input logic               txrst,
  ipsmacge_txctrl_if.master bus
);
  typedef enum logic [STT_DW-1:0] {
    IGAP = STT_DW'(0), IRDY = STT_DW'(1), IPRM = STT_DW'(2), IPAY = STT_DW'(3),
    IFCS = STT_DW'(4), IFCE = STT_DW'(5), IPAD = STT_DW'(7), IDIS = STT_DW'(8)
  } stt_e;

  // One byte slot as presented to the insert stage.
  typedef struct packed {
    logic [STT_DW-1:0] stt;
    logic [CNT_DW-1:0] cnt;
    logic              sfd;
    logic [DAT_DW-1:0] dat;
    logic              err;
    logic              crcclr;
    logic              crcen;
  } slot_t;

  localparam logic [CNT_DW-1:0] CNT_MAX  = '1;
  localparam logic [CNT_DW-1:0] IPG_LAST = CNT_DW'(IPG_LEN - 1);
  localparam logic [CNT_DW-1:0] PRM_LAST = CNT_DW'(PRM_LEN - 1);
  localparam logic [CNT_DW-1:0] PAD_LAST = CNT_DW'(MIN_LEN - 1);
  localparam logic [CNT_DW-1:0] FCS_LAST = CNT_DW'(3);
  localparam slot_t SLOT_DIS = '{stt: IDIS, default: '0};

  stt_e              stt_q, stt_d, fcs_stt;
  logic [CNT_DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic              flush_q, flush_d;
  logic              errl_q, errl_d;
  slot_t             slot_q, slot_d, cur;
  logic              dis, pop, ofrd;

  always_comb begin
    dis     = !bus.uptxen || !bus.spdstable;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // A disable in the same slot as a payload pop wins, so that byte stays for the flush.
    pop     = bus.pena && !dis && (stt_q == IPAY);
    ofrd    = pop || (flush_q && bus.ifrmrdy);

    flush_d = flush_q;
    if (flush_q && bus.ifrmrdy && bus.ifeop) flush_d = 1'b0;
    if (dis && stt_q == IPAY)                flush_d = 1'b1;

    cur     = '0;
    cur.stt = stt_q;
    cur.cnt = cnt_q;
    case (stt_q)
      IPRM: begin
        cur.crcclr = 1'b1;
        cur.sfd    = (cnt_q == PRM_LAST);
      end
      IPAY: begin
        cur.dat   = bus.ifdat;
        cur.err   = bus.iferr;
        cur.crcen = 1'b1;
      end
      IPAD:    cur.crcen = 1'b1;
      default: ;
    endcase
    if (dis) cur = SLOT_DIS;
    slot_d = bus.pena ? cur : slot_q;

    stt_d  = stt_q;
    cnt_d  = cnt_q;
    errl_d = errl_q;
    if (pop) errl_d = errl_q | bus.iferr;
    fcs_stt = errl_d ? IFCE : IFCS;

    if (dis) begin
      stt_d = IDIS;
      cnt_d = '0;
    end else if (bus.pena) begin
      case (stt_q)
        IDIS: if (!flush_q) begin stt_d = IGAP; cnt_d = '0; end
        IGAP: if (cnt_q == IPG_LAST) begin stt_d = IRDY; cnt_d = '0; end
              else cnt_d = cnt_inc;
        IRDY: if (bus.ifrmrdy) begin stt_d = IPRM; cnt_d = '0; end
        IPRM: if (cnt_q == PRM_LAST) begin stt_d = IPAY; cnt_d = '0; errl_d = 1'b0; end
              else cnt_d = cnt_inc;
        IPAY: if (bus.ifeop) begin
                if (cnt_q < PAD_LAST) begin stt_d = IPAD; cnt_d = cnt_inc; end
                else begin stt_d = fcs_stt; cnt_d = '0; end
              end else cnt_d = cnt_inc;
        IPAD: if (cnt_q == PAD_LAST) begin stt_d = fcs_stt; cnt_d = '0; end
              else cnt_d = cnt_inc;
        IFCS, IFCE: if (cnt_q == FCS_LAST) begin stt_d = IGAP; cnt_d = '0; end
                    else cnt_d = cnt_inc;
        default: begin stt_d = IDIS; cnt_d = '0; end
      endcase
    end
  end

  always_ff @(posedge txclk) begin
    if (txrst) begin
      stt_q   <= IDIS;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      errl_q  <= 1'b0;
      slot_q  <= SLOT_DIS;
    end else begin
      stt_q   <= stt_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      errl_q  <= errl_d;
      slot_q  <= slot_d;
    end
  end

  assign bus.ofrd    = ofrd;
  assign bus.osttm   = slot_q.stt;
  assign bus.ocnt    = slot_q.cnt;
  assign bus.osfd    = slot_q.sfd;
  assign bus.odat    = slot_q.dat;
  assign bus.oerr    = slot_q.err;
  assign bus.ocrcclr = slot_q.crcclr;
  assign bus.ocrcen  = slot_q.crcen;
endmodule

// File: tb/tb_ipsmacge_txctrl.sv
// Bench for ipsmacge_txctrl: expected byte-slot stream is built from frame lengths,
// a FIFO model feeds the DUT, and one compare process checks every slot.
`timescale 1ns/1ps
module tb_ipsmacge_txctrl;
  localparam int IPG = 12, PRM = 8, MINL = 60;
  localparam int S_GAP = 0, S_RDY = 1, S_PRM = 2, S_PAY = 3, S_FCS = 4, S_FCE = 5, S_PAD = 7, S_DIS = 8;

  typedef struct packed {
    logic [3:0] stt; logic [5:0] cnt; logic sfd; logic [7:0] dat;
    logic err; logic clr; logic en; logic rd;
  } slot_t;
  typedef struct packed {logic [7:0] dat; logic eop; logic err;} fbyte_t;

  logic txclk = 1'b0;
  logic txrst = 1'b1;
  ipsmacge_txctrl_if #(.DAT_DW(8), .CNT_DW(6), .STT_DW(4)) bus ();
  ipsmacge_txctrl #(.DAT_DW(8), .CNT_DW(6), .STT_DW(4), .IPG_LEN(IPG), .PRM_LEN(PRM), .MIN_LEN(MINL))
    dut (.txclk(txclk), .txrst(txrst), .bus(bus));
  always #5 txclk = ~txclk;

  slot_t  expq[$];
  fbyte_t fifo[$];
  slot_t  last;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b0, rd_seen = 1'b0, pena_seen = 1'b0;
  int c_rd, c_sfd, c_pad, c_err, c_fce, gap_run, last_gap;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- expected slot stream, from the framing rules ----
  task automatic add(input int stt, input int cnt, input int dat,
                     input bit sfd, input bit err, input bit clr, input bit en, input bit rd);
    slot_t s;
    s.stt = 4'(stt); s.cnt = 6'(cnt); s.dat = 8'(dat);
    s.sfd = sfd; s.err = err; s.clr = clr; s.en = en; s.rd = rd;
    expq.push_back(s);
  endtask

  task automatic add_gap();
    for (int i = 0; i < IPG; i++) add(S_GAP, i, 0, 0, 0, 0, 0, 0);
    add(S_RDY, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_frame(input int len, input int errpos, input int base);
    for (int i = 0; i < PRM; i++) add(S_PRM, i, 0, i == PRM - 1, 0, 1, 0, 0);
    for (int i = 0; i < len; i++) add(S_PAY, (i > 63) ? 63 : i, base + i, 0, i == errpos, 0, 1, 1);
    for (int i = len; i < MINL; i++) add(S_PAD, i, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add((errpos >= 0) ? S_FCE : S_FCS, i, 0, 0, 0, 0, 0, 0);
    add_gap();
  endtask

  task automatic push_frame(input int len, input int errpos, input int base);
    fbyte_t b;
    for (int i = 0; i < len; i++) begin
      b.dat = 8'(base + i); b.eop = (i == len - 1); b.err = (i == errpos);
      fifo.push_back(b);
    end
  endtask

  // ---- FIFO model and per-cycle driver ----
  task automatic drive_head();
    int n = 0;
    foreach (fifo[i]) if (fifo[i].eop) n++;
    bus.ifrmrdy = (n > 0);
    if (fifo.size() > 0) {bus.ifdat, bus.ifeop, bus.iferr} = fifo[0];
    else {bus.ifdat, bus.ifeop, bus.iferr} = '0;
  endtask

  task automatic cycle(input bit p, input bit sp);
    bus.pena = p; bus.spdstable = sp;
    drive_head();
    #2;
    rd_seen = bus.ofrd; pena_seen = p;
    @(posedge txclk); #1;
    if (rd_seen && fifo.size() > 0) fifo.delete(0);
    @(negedge txclk);
  endtask

  // ---- the single compare process ----
  always @(posedge txclk) begin : cmp_p
    slot_t e, a;
    #2;
    if (chk_on) begin
      a = '{stt: bus.osttm, cnt: bus.ocnt, sfd: bus.osfd, dat: bus.odat, err: bus.oerr,
            clr: bus.ocrcclr, en: bus.ocrcen, rd: rd_seen};
      if (a.rd) c_rd++;
      if (pena_seen) begin
        if (a.sfd) c_sfd++;
        if (a.stt == 4'(S_PAD)) c_pad++;
        if (a.err) c_err++;
        if (a.stt == 4'(S_FCE)) c_fce++;
        if (a.stt == 4'(S_GAP) || a.stt == 4'(S_RDY)) gap_run++;
        else begin
          if (a.stt == 4'(S_PRM) && a.cnt == 6'd0) last_gap = gap_run;
          gap_run = 0;
        end
      end
      if (pena_seen && expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL slot_underrun: got slot %h want no further slot", a);
      end else begin
        if (pena_seen) begin e = expq.pop_front(); last = e; end
        else begin e = last; e.rd = 1'b0; end
        chk("slot{stt,cnt,sfd,dat,err,clr,en,rd}", 64'(a), 64'(e));
      end
    end
  end

  task automatic do_reset();
    chk_on = 1'b0; txrst = 1'b1; bus.uptxen = 1'b1;
    cycle(1, 1); cycle(1, 1);
    txrst = 1'b0;
    last = '0; last.stt = 4'(S_DIS);
    c_rd = 0; c_sfd = 0; c_pad = 0; c_err = 0; c_fce = 0; gap_run = 0; last_gap = -1;
    chk("rst_osttm", 64'(bus.osttm), 64'd8);
    chk("rst_ocnt", 64'(bus.ocnt), 64'd0);
    chk("rst_odat", 64'(bus.odat), 64'd0);
    chk("rst_flags{sfd,err,clr,en,rd}",
        64'({bus.osfd, bus.oerr, bus.ocrcclr, bus.ocrcen, bus.ofrd}), 64'd0);
  endtask

  task automatic run(input int drop_at, input bit toggle);
    int n;
    n = expq.size();
    chk_on = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle(1, i != drop_at);
      if (toggle) cycle(0, 1);
    end
    chk_on = 1'b0;
    chk("exp_drained", 64'(expq.size()), 64'd0);
    chk("fifo_drained", 64'(fifo.size()), 64'd0);
  endtask

  task automatic lead();
    add(S_DIS, 0, 0, 0, 0, 0, 0, 0);
    add_gap();
  endtask

  initial begin
    int drop_at;
    bus.pena = 1'b0; bus.uptxen = 1'b1; bus.spdstable = 1'b1;
    bus.ifrmrdy = 1'b0; bus.ifdat = '0; bus.ifeop = 1'b0; bus.iferr = 1'b0;
    @(negedge txclk);

    // 64-byte frame, no padding
    do_reset(); push_frame(64, -1, 'h10); lead(); add_frame(64, -1, 'h10);
    run(-1, 0);
    chk("A_pops", 64'(c_rd), 64'd64);
    chk("A_sfd_count", 64'(c_sfd), 64'd1);

    // 20-byte frame padded to 60
    do_reset(); push_frame(20, -1, 'h40); lead(); add_frame(20, -1, 'h40);
    run(-1, 0);
    chk("B_pad_slots", 64'(c_pad), 64'd40);
    chk("B_pops", 64'(c_rd), 64'd20);

    // errored byte 10 -> IFCE
    do_reset(); push_frame(64, 10, 'h80); lead(); add_frame(64, 10, 'h80);
    run(-1, 0);
    chk("C_oerr_slots", 64'(c_err), 64'd1);
    chk("C_ifce_slots", 64'(c_fce), 64'd4);

    // pena toggling: same slot stream, outputs held on pena=0
    do_reset(); push_frame(64, -1, 'h10); lead(); add_frame(64, -1, 'h10);
    run(-1, 1);
    chk("D_pops", 64'(c_rd), 64'd64);
    chk("D_sfd_count", 64'(c_sfd), 64'd1);

    // speed loss at payload byte 30 of 64, flush, then a 20-byte frame
    do_reset(); push_frame(64, -1, 'h20); push_frame(20, -1, 'hA0); lead();
    for (int i = 0; i < PRM; i++) add(S_PRM, i, 0, i == PRM - 1, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) add(S_PAY, i, 'h20 + i, 0, 0, 0, 1, 1);
    drop_at = expq.size();
    for (int j = 0; j < 36; j++) add(S_DIS, 0, 0, 0, 0, 0, 0, j >= 1 && j <= 34);
    add_gap(); add_frame(20, -1, 'hA0);
    run(drop_at, 0);
    chk("E_pops", 64'(c_rd), 64'd84);

    // back-to-back frames, second one long enough to saturate ocnt
    do_reset(); push_frame(64, -1, 'h01); push_frame(70, -1, 'h55);
    lead(); add_frame(64, -1, 'h01); add_frame(70, -1, 'h55);
    run(-1, 0);
    chk("F_gap_slots", 64'(last_gap), 64'd13);
    chk("F_pops", 64'(c_rd), 64'd134);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
